// File: rtl/sel_decode_pkg.sv
// Shared widths and the one-hot helper used by the select decoders.
package sel_decode_pkg;

    localparam int DEC2_W       = 4;
    localparam int DEC3_W       = 8;
    // Widest one-hot vector the helper can build; callers truncate to their width.
    localparam int ONEHOT_MAX_W = 256;

    // Bit `sel` set when it falls inside `width`, every other bit clear.
    function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int sel, input int width);
        logic [ONEHOT_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < ONEHOT_MAX_W; i++) begin
            if (i < width && i == sel) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sel_decode_onehot_dec.sv
// Combinational select-to-one-hot decoder with enable; all-zero when disabled.
module onehot_dec
    import sel_decode_pkg::*;
#(
    parameter  int SEL_W = 2,
    localparam int OUT_W = 1 << SEL_W
) (
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] y
);

    // Decode the select into a single strobe, gated by the enable.
    always_comb begin
        y = '0;
        if (en) y = OUT_W'(onehot(int'(sel), OUT_W));
    end

endmodule

// File: rtl/sel_decode_unit.sv
// Registered select decode: 2-to-4 and 3-to-8 one-hot decoders plus a 1-to-2 demux.
// Every output is a flop, so inputs show up exactly one clock later.
module sel_decode_unit
    import sel_decode_pkg::*;
#(
    parameter int N2 = 2,
    parameter int N3 = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec2_en,
    input  logic [N2-1:0]     in_d2,
    output logic [2**N2-1:0]  Y_decoder2,
    input  logic              dec3_en,
    input  logic [N3-1:0]     in_d3,
    output logic [2**N3-1:0]  Y_decoder3,
    input  logic              din,
    input  logic              sel,
    output logic              y1,
    output logic              y2
);

    logic [2**N2-1:0] dec2_nxt;
    logic [2**N3-1:0] dec3_nxt;

    onehot_dec #(.SEL_W(N2)) u_dec2 (
        .en  (dec2_en),
        .sel (in_d2),
        .y   (dec2_nxt)
    );

    onehot_dec #(.SEL_W(N3)) u_dec3 (
        .en  (dec3_en),
        .sel (in_d3),
        .y   (dec3_nxt)
    );

    // Output registers for all lanes; the demux steers din to the selected side only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y_decoder2 <= '0;
            Y_decoder3 <= '0;
            y1         <= 1'b0;
            y2         <= 1'b0;
        end else begin
            Y_decoder2 <= dec2_nxt;
            Y_decoder3 <= dec3_nxt;
            y1         <= din & ~sel;
            y2         <= din &  sel;
        end
    end

endmodule

// File: tb/tb_sel_decode_unit.sv
// Self-checking bench for sel_decode_unit: directed table, reset sequences, random traffic.
module tb_sel_decode_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       dec2_en, dec3_en, din, sel;
    logic [1:0] in_d2;
    logic [2:0] in_d3;
    logic [3:0] Y_decoder2;
    logic [7:0] Y_decoder3;
    logic       y1, y2;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic       en2;
        logic [1:0] d2;
        logic       en3;
        logic [2:0] d3;
        logic       din;
        logic       sel;
        logic [3:0] e2;
        logic [7:0] e3;
        logic       ey1;
        logic       ey2;
    } vec_t;

    vec_t tbl[$];

    sel_decode_unit #(.N2(2), .N3(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dec2_en    (dec2_en),
        .in_d2      (in_d2),
        .Y_decoder2 (Y_decoder2),
        .dec3_en    (dec3_en),
        .in_d3      (in_d3),
        .Y_decoder3 (Y_decoder3),
        .din        (din),
        .sel        (sel),
        .y1         (y1),
        .y2         (y2)
    );

    always #5 clk = ~clk;

    // Invariants sampled mid-cycle whenever reset is released.
    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            assert ($onehot0(Y_decoder2) && $onehot0(Y_decoder3) && !(y1 && y2))
                n_pass++;
            else
                $display("FAIL invariant: dec2=%b dec3=%b y1=%b y2=%b (need <=1 bit each, y1&y2=0)",
                         Y_decoder2, Y_decoder3, y1, y2);
        end
    end

    function automatic vec_t mk(input logic en2, input int d2, input logic en3, input int d3,
                                input logic di, input logic s, input int e2, input int e3,
                                input logic ey1, input logic ey2);
        vec_t v;
        v.en2 = en2; v.d2 = 2'(d2); v.en3 = en3; v.d3 = 3'(d3);
        v.din = di;  v.sel = s;     v.e2 = 4'(e2); v.e3 = 8'(e3);
        v.ey1 = ey1; v.ey2 = ey2;
        return v;
    endfunction

    // Reference behaviour from the decode/steer rules, using plain arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   p2, p3;
        r  = v;
        p2 = 1;
        for (int k = 0; k < int'(v.d2); k++) p2 = p2 * 2;
        p3 = 1;
        for (int k = 0; k < int'(v.d3); k++) p3 = p3 * 2;
        r.e2  = v.en2 ? 4'(p2) : 4'd0;
        r.e3  = v.en3 ? 8'(p3) : 8'd0;
        r.ey1 = (v.din == 1'b1 && v.sel == 1'b0);
        r.ey2 = (v.din == 1'b1 && v.sel == 1'b1);
        return r;
    endfunction

    task automatic drive(input vec_t v);
        dec2_en = v.en2; in_d2 = v.d2; dec3_en = v.en3; in_d3 = v.d3;
        din = v.din; sel = v.sel;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".dec2"}, int'(Y_decoder2), int'(v.e2));
        chk({tag, ".dec3"}, int'(Y_decoder3), int'(v.e3));
        chk({tag, ".y1"},   int'(y1),         int'(v.ey1));
        chk({tag, ".y2"},   int'(y2),         int'(v.ey2));
    endtask

    task automatic chk_zero(input string tag);
        chk_all(tag, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        vec_t v;

        //   en2 d2 en3 d3 din sel  e2    e3     y1 y2
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 'h1, 'h01, 1, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 'h2, 'h02, 0, 1));
        tbl.push_back(mk(1, 2, 1, 2, 0, 0, 'h4, 'h04, 0, 0));
        tbl.push_back(mk(1, 3, 1, 3, 0, 1, 'h8, 'h08, 0, 0));
        tbl.push_back(mk(1, 0, 1, 4, 1, 0, 'h1, 'h10, 1, 0));
        tbl.push_back(mk(0, 2, 1, 5, 1, 1, 'h0, 'h20, 0, 1));
        tbl.push_back(mk(1, 3, 1, 6, 0, 0, 'h8, 'h40, 0, 0));
        tbl.push_back(mk(1, 3, 1, 7, 1, 0, 'h8, 'h80, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 1, 'h1, 'h01, 0, 0));
        tbl.push_back(mk(0, 1, 0, 3, 1, 0, 'h0, 'h00, 1, 0));
        tbl.push_back(mk(1, 3, 1, 5, 1, 1, 'h8, 'h20, 0, 1));

        // Reset with arbitrary inputs clears outputs without any clock edge.
        drive(mk(1, 2, 1, 6, 1, 1, 0, 0, 0, 0));
        #1 rst_n = 1'b0;
        #1 chk_zero("reset_async");
        repeat (2) step();
        chk_zero("reset_hold");

        // Release between edges; the first edge captures the current inputs.
        drive(tbl[0]);
        #2 rst_n = 1'b1;
        step();
        chk_all("first_capture", tbl[0]);

        // Directed table: sweeps, select wraps, enables off, demux cases, concurrency.
        foreach (tbl[i]) begin
            drive(tbl[i]);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i]);
        end

        // Mid-stream reset clears at once; first capture after release is the live inputs.
        drive(tbl[10]);
        step();
        chk_all("pre_midreset", tbl[10]);
        #1 rst_n = 1'b0;
        #1 chk_zero("midreset");
        v = mk(1, 1, 1, 2, 1, 0, 'h2, 'h04, 1, 0);
        drive(v);
        #1 rst_n = 1'b1;
        step();
        chk_all("post_midreset", v);

        // Random traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            v.en2 = 1'($urandom_range(0, 3) != 0);
            v.d2  = 2'($urandom);
            v.en3 = 1'($urandom_range(0, 3) != 0);
            v.d3  = 3'($urandom);
            v.din = 1'($urandom);
            v.sel = 1'($urandom);
            v = model(v);
            drive(v);
            step();
            chk_all($sformatf("rand%0d", i), v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
